// File: rtl/phase_step_sweeper_if.sv
// Bundle of sweep control, configuration and status signals between a sweep
// controller (master) and the phase_step_sweeper (slave).
interface phase_step_sweeper_if #(
    parameter int PHASE_STEP_WIDTH = 32,
    parameter int DWELL_WIDTH      = 16
);
    logic                        start;
    logic                        abort;
    logic [PHASE_STEP_WIDTH-1:0] start_step;
    logic [PHASE_STEP_WIDTH-1:0] stop_step;
    logic [PHASE_STEP_WIDTH-1:0] step_increment;
    logic [DWELL_WIDTH-1:0]      dwell_cycles;
    logic                        bidirectional;
    logic                        repeat_sweep;
    logic [PHASE_STEP_WIDTH-1:0] phase_step;
    logic                        busy;
    logic                        direction;
    logic                        sweep_done;
    logic                        config_error;

    modport master (
        output start, abort, start_step, stop_step, step_increment,
               dwell_cycles, bidirectional, repeat_sweep,
        input  phase_step, busy, direction, sweep_done, config_error
    );

    modport slave (
        input  start, abort, start_step, stop_step, step_increment,
               dwell_cycles, bidirectional, repeat_sweep,
        output phase_step, busy, direction, sweep_done, config_error
    );
endinterface

// File: rtl/phase_step_sweeper.sv
// Linear chirp generator feeding the sine generator's phase_step input.
// Walks phase_step from start to stop in fixed increments, holding each value
// for dwell+1 clocks, with optional down-sweep and continuous repeat.
module phase_step_sweeper #(
    parameter int PHASE_STEP_WIDTH = 32,
    parameter int DWELL_WIDTH      = 16
) (
    input logic                 clock,
    input logic                 reset,
    phase_step_sweeper_if.slave bus
);
    localparam int PSW = PHASE_STEP_WIDTH;
    localparam int DW  = DWELL_WIDTH;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SWEEP_UP   = 2'd1;
    localparam logic [1:0] SWEEP_DOWN = 2'd2;

    logic [1:0]     state_q,    state_d;
    logic [PSW-1:0] phase_q,    phase_d;
    logic [DW-1:0]  dwellCnt_q, dwellCnt_d;
    logic [PSW-1:0] start_q,    start_d;
    logic [PSW-1:0] stop_q,     stop_d;
    logic [PSW-1:0] inc_q,      inc_d;
    logic [DW-1:0]  dwell_q,    dwell_d;
    logic           bidir_q,    bidir_d;
    logic           repeat_q,   repeat_d;
    logic           done_q,     done_d;
    logic           err_q,      err_d;

    logic [PSW:0]   upSum;
    logic [PSW:0]   restartSum;
    logic [PSW-1:0] upNext;
    logic [PSW-1:0] restartNext;
    logic [PSW-1:0] downNext;
    logic [PSW-1:0] turnNext;
    logic           holdDone;

    // Clamped candidate steps, computed one bit wider or borrow-safe so nothing wraps.
    always_comb begin
        upSum       = {1'b0, phase_q} + {1'b0, inc_q};
        restartSum  = {1'b0, start_q} + {1'b0, inc_q};
        upNext      = (upSum > {1'b0, stop_q}) ? stop_q : upSum[PSW-1:0];
        restartNext = (restartSum > {1'b0, stop_q}) ? stop_q : restartSum[PSW-1:0];
        downNext    = ((phase_q - start_q) > inc_q) ? (phase_q - inc_q) : start_q;
        turnNext    = ((stop_q - start_q) > inc_q) ? (stop_q - inc_q) : start_q;
        holdDone    = (dwellCnt_q == dwell_q);
    end

    // Next-state logic: config latch on start, dwell counting and step/direction updates.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dwellCnt_d = dwellCnt_q;
        start_d    = start_q;
        stop_d     = stop_q;
        inc_d      = inc_q;
        dwell_d    = dwell_q;
        bidir_d    = bidir_q;
        repeat_d   = repeat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (bus.abort) begin
            state_d    = IDLE;
            dwellCnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.step_increment == '0) || (bus.start_step > bus.stop_step)) begin
                            err_d = 1'b1;
                        end else begin
                            start_d    = bus.start_step;
                            stop_d     = bus.stop_step;
                            inc_d      = bus.step_increment;
                            dwell_d    = bus.dwell_cycles;
                            bidir_d    = bus.bidirectional;
                            repeat_d   = bus.repeat_sweep;
                            phase_d    = bus.start_step;
                            dwellCnt_d = '0;
                            state_d    = SWEEP_UP;
                        end
                    end
                end
                SWEEP_UP: begin
                    if (!holdDone) begin
                        dwellCnt_d = dwellCnt_q + 1'b1;
                    end else begin
                        dwellCnt_d = '0;
                        if (phase_q != stop_q) begin
                            phase_d = upNext;
                        end else if (bidir_q && (start_q != stop_q)) begin
                            state_d = SWEEP_DOWN;
                            phase_d = turnNext;
                        end else if (repeat_q) begin
                            phase_d = start_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                SWEEP_DOWN: begin
                    if (!holdDone) begin
                        dwellCnt_d = dwellCnt_q + 1'b1;
                    end else begin
                        dwellCnt_d = '0;
                        if (phase_q != start_q) begin
                            phase_d = downNext;
                        end else if (repeat_q) begin
                            state_d = SWEEP_UP;
                            phase_d = restartNext;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    dwellCnt_d = '0;
                end
            endcase
        end
    end

    // State, config and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            dwellCnt_q <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            inc_q      <= '0;
            dwell_q    <= '0;
            bidir_q    <= 1'b0;
            repeat_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dwellCnt_q <= dwellCnt_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            inc_q      <= inc_d;
            dwell_q    <= dwell_d;
            bidir_q    <= bidir_d;
            repeat_q   <= repeat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.phase_step   = phase_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.direction    = (state_q == SWEEP_DOWN);
    assign bus.sweep_done   = done_q;
    assign bus.config_error = err_q;
endmodule

// File: tb/tb_phase_step_sweeper.sv
// Bench for phase_step_sweeper: a list-based model of the sweep is checked
// against the DUT every cycle, plus literal sequences for the key scenarios.
module tb_phase_step_sweeper;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    phase_step_sweeper_if #(.PHASE_STEP_WIDTH(32), .DWELL_WIDTH(16)) bus ();

    phase_step_sweeper #(.PHASE_STEP_WIDTH(32), .DWELL_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    // Model: the whole sweep as a list of distinct values, walked one entry per dwell period.
    longint      seq [0:255];
    int          seqLen, upLen, loopIdx, idx, holdCnt, mDwell;
    bit          mRepeat;
    logic [31:0] mPhase = '0;
    logic        mBusy = 1'b0, mDir = 1'b0, mDone = 1'b0, mErr = 1'b0;

    logic [31:0] expVals [$];
    logic        expDirs [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic buildSeq(input longint s, input longint e, input longint inc, input bit bi);
        longint v;
        seqLen = 0;
        v = s;
        seq[seqLen] = v; seqLen = seqLen + 1;
        while (v != e && seqLen < 120) begin
            v = (v + inc > e) ? e : v + inc;
            seq[seqLen] = v; seqLen = seqLen + 1;
        end
        upLen = seqLen;
        if (bi && s != e) begin
            v = e;
            while (v != s && seqLen < 250) begin
                v = (v - inc < s) ? s : v - inc;
                seq[seqLen] = v; seqLen = seqLen + 1;
            end
            loopIdx = 1;
        end else begin
            loopIdx = 0;
        end
    endtask

    task automatic stepModel();
        mDone = 1'b0;
        mErr  = 1'b0;
        if (reset) begin
            mPhase = '0; mBusy = 1'b0; mDir = 1'b0;
        end else if (bus.abort) begin
            mBusy = 1'b0; mDir = 1'b0;
        end else if (!mBusy) begin
            if (bus.start) begin
                if (bus.step_increment == 0 || bus.start_step > bus.stop_step) begin
                    mErr = 1'b1;
                end else begin
                    buildSeq(longint'(bus.start_step), longint'(bus.stop_step),
                             longint'(bus.step_increment), bus.bidirectional);
                    mDwell  = int'(bus.dwell_cycles);
                    mRepeat = bus.repeat_sweep;
                    idx = 0; holdCnt = 0;
                    mBusy = 1'b1; mDir = 1'b0;
                    mPhase = seq[0][31:0];
                end
            end
        end else if (holdCnt < mDwell) begin
            holdCnt = holdCnt + 1;
        end else begin
            holdCnt = 0;
            idx = idx + 1;
            if (idx >= seqLen) begin
                if (mRepeat) idx = loopIdx;
                else begin
                    mBusy = 1'b0; mDir = 1'b0; mDone = 1'b1;
                end
            end
            if (mBusy) begin
                mPhase = seq[idx][31:0];
                mDir   = (idx >= upLen);
            end
        end
    endtask

    always @(posedge clock) stepModel();

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmpEn) begin
            checkOutput("model_phase", bus.phase_step, mPhase);
            checkOutput("model_busy", 32'(bus.busy), 32'(mBusy));
            checkOutput("model_dir", 32'(bus.direction), 32'(mDir));
            checkOutput("model_done", 32'(bus.sweep_done), 32'(mDone));
            checkOutput("model_err", 32'(bus.config_error), 32'(mErr));
        end
    end

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                                 input logic [15:0] dw, input logic bi, input logic rp);
        @(posedge clock); #1;
        bus.start_step = s; bus.stop_step = e; bus.step_increment = inc;
        bus.dwell_cycles = dw; bus.bidirectional = bi; bus.repeat_sweep = rp;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic checkSeq(input string name, input bit withDir);
        foreach (expVals[i]) begin
            @(negedge clock);
            checkOutput({name, "_phase"}, bus.phase_step, expVals[i]);
            checkOutput({name, "_busy"}, 32'(bus.busy), 32'd1);
            if (withDir) checkOutput({name, "_dir"}, 32'(bus.direction), 32'(expDirs[i]));
        end
    endtask

    task automatic checkDone(input string name, input logic [31:0] finalPhase);
        @(negedge clock);
        checkOutput({name, "_done"}, 32'(bus.sweep_done), 32'd1);
        checkOutput({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
        checkOutput({name, "_hold"}, bus.phase_step, finalPhase);
        @(negedge clock);
        checkOutput({name, "_done_pulse"}, 32'(bus.sweep_done), 32'd0);
    endtask

    initial begin
        int cycles;
        int abortAt;
        logic [31:0] s, inc;
        longint e;

        bus.start = 0; bus.abort = 0; bus.start_step = 0; bus.stop_step = 0;
        bus.step_increment = 0; bus.dwell_cycles = 0; bus.bidirectional = 0; bus.repeat_sweep = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_phase", bus.phase_step, 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.sweep_done), 32'd0);
        checkOutput("reset_err", 32'(bus.config_error), 32'd0);
        reset = 1'b0;
        cmpEn = 1'b1;

        // Scenario 1: dwell of one extra cycle
        applyStimulus(100, 130, 10, 1, 0, 0);
        expVals = '{100, 100, 110, 110, 120, 120, 130, 130};
        checkSeq("t1", 1'b0);
        checkDone("t1", 130);

        // Scenario 2: last step clamped to stop
        applyStimulus(0, 25, 10, 0, 0, 0);
        expVals = '{0, 10, 20, 25};
        checkSeq("t2", 1'b0);
        checkDone("t2", 25);

        // Scenario 3: top of range, no wrap
        applyStimulus(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 0, 0, 0);
        expVals = '{32'hFFFFFFF0, 32'hFFFFFFFF};
        checkSeq("t3", 1'b0);
        checkDone("t3", 32'hFFFFFFFF);

        // Scenario 4: bidirectional repeat, then abort
        applyStimulus(10, 30, 10, 0, 1, 1);
        expVals = '{10, 20, 30, 20, 10, 20, 30};
        expDirs = '{0, 0, 0, 1, 1, 0, 0};
        checkSeq("t4", 1'b1);
        bus.abort = 1'b1;
        @(posedge clock); #1;
        bus.abort = 1'b0;
        @(negedge clock);
        checkOutput("t4_abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("t4_abort_phase", bus.phase_step, 32'd30);
        checkOutput("t4_abort_dir", 32'(bus.direction), 32'd0);
        checkOutput("t4_abort_nodone", 32'(bus.sweep_done), 32'd0);

        // Scenario 5: rejected configurations
        applyStimulus(10, 40, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("t5_inc0_err", 32'(bus.config_error), 32'd1);
        checkOutput("t5_inc0_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_inc0_phase", bus.phase_step, 32'd30);
        applyStimulus(50, 40, 5, 0, 0, 0);
        @(negedge clock);
        checkOutput("t5_order_err", 32'(bus.config_error), 32'd1);
        @(negedge clock);
        checkOutput("t5_err_pulse", 32'(bus.config_error), 32'd0);

        // Scenario 6: reset mid-sweep with a coincident start
        applyStimulus(100, 200, 10, 2, 1, 0);
        repeat (4) @(negedge clock);
        reset = 1'b1; bus.start = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("t6_phase", bus.phase_step, 32'd0);
        checkOutput("t6_busy", 32'(bus.busy), 32'd0);
        checkOutput("t6_dir", 32'(bus.direction), 32'd0);
        reset = 1'b0; bus.start = 1'b0;

        // Randomized sweeps with mid-sweep noise on config and start inputs
        for (int iter = 0; iter < 40; iter++) begin
            s   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 5000)) : $urandom;
            inc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 500);
            if (inc == 0) inc = 1;
            e = longint'(s) + longint'($urandom_range(0, 40)) * longint'(inc)
                + longint'($urandom_range(0, 32'(inc - 1)));
            if (e > 64'hFFFFFFFF) e = 64'hFFFFFFFF;
            if ($urandom_range(0, 9) == 0) inc = 0;
            if ($urandom_range(0, 9) == 0 && s > 0) e = longint'(s) - 1;
            applyStimulus(s, e[31:0], inc, 16'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            abortAt = bus.repeat_sweep ? $urandom_range(20, 300) : 100000;
            cycles = 0;
            while (mBusy && cycles < 3000) begin
                @(posedge clock); #1;
                cycles++;
                bus.start_step = $urandom; bus.stop_step = $urandom;
                bus.step_increment = $urandom; bus.dwell_cycles = 16'($urandom);
                bus.bidirectional = 1'($urandom); bus.repeat_sweep = 1'($urandom);
                bus.start = ($urandom_range(0, 15) == 0);
                bus.abort = (cycles >= abortAt) || ($urandom_range(0, 299) == 0);
            end
            if (cycles >= 3000) begin
                checks++; errors++;
                $display("[TB] FAIL timeout: busy still 1 after %0d cycles, expected 0", cycles);
            end
            bus.start = 1'b0; bus.abort = 1'b0;
            repeat (2) @(posedge clock);
            #1;
        end

        @(negedge clock);
        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
